// File: rtl/nn_timestep_scheduler.sv
// ---------------------------------------------------------------------------
// nn_timestep_scheduler
//
// Runs the spiking neural-network core for a programmed number of discrete
// timesteps. The host pushes input spike vectors into a small FIFO. For each
// timestep the scheduler pops one vector, holds it on nn_input_spikes for
// STEP_CYCLES clocks, and ORs together every output spike seen during that
// window. At the end of the window each neuron that fired at least once has
// its saturating spike counter incremented.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a run (only looked at while idle)
//   abort             return to idle from any state, keeping partial results
//   num_steps         number of timesteps in the run, latched on start
//   in_valid/in_ready/in_spikes
//                     host-side push interface into the vector FIFO
//   nn_clear          one-cycle pulse that clears core state at run start
//   nn_input_spikes   spike vector driven into the core (0 when not applying)
//   nn_output_spikes  spikes produced by the core
//   spike_count       per-neuron counts, neuron i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   step_idx          timesteps completed in the current/last run
//   busy              high whenever a run is in progress
//   stall             high while waiting for the host to supply a vector
//   done              one-cycle pulse when a run completes normally
// ---------------------------------------------------------------------------
module nn_timestep_scheduler #(
    parameter int NUM_NEURONS = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int STEP_CYCLES = 4,
    parameter int COUNT_WIDTH = 8,
    parameter int STEPS_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [STEPS_WIDTH-1:0]             num_steps,
    input  logic                               in_valid,
    input  logic [NUM_NEURONS-1:0]             in_spikes,
    output logic                               in_ready,
    output logic                               nn_clear,
    output logic [NUM_NEURONS-1:0]             nn_input_spikes,
    input  logic [NUM_NEURONS-1:0]             nn_output_spikes,
    output logic [NUM_NEURONS*COUNT_WIDTH-1:0] spike_count,
    output logic [STEPS_WIDTH-1:0]             step_idx,
    output logic                               busy,
    output logic                               stall,
    output logic                               done
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int PHASE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_APPLY = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [2:0]             state;
    logic [2:0]             state_next;

    logic [NUM_NEURONS-1:0] fifo_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;

    logic [NUM_NEURONS-1:0] hold;
    logic [NUM_NEURONS-1:0] accum;
    logic [NUM_NEURONS-1:0] step_sample;
    logic [PHASE_W-1:0]     phase;
    logic                   last_phase;
    logic [STEPS_WIDTH-1:0] num_steps_lat;
    logic [STEPS_WIDTH-1:0] step_next;
    logic [COUNT_WIDTH-1:0] cnt [0:NUM_NEURONS-1];

    // FIFO status and handshakes. A vector only leaves the FIFO on the
    // FETCH->APPLY transition, and an abort in FETCH must leave it in place.
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    assign pop        = (state == S_FETCH) && !fifo_empty && !abort;

    // The last cycle of a timestep counts the sample arriving on that same
    // cycle as well as everything accumulated so far.
    assign last_phase  = (phase == PHASE_W'(STEP_CYCLES - 1));
    assign step_sample = accum | nn_output_spikes;
    assign step_next   = step_idx + STEPS_WIDTH'(1);

    // Outputs are pure decodes of registered state so the core and host
    // never see combinational paths from our inputs.
    assign busy            = (state != S_IDLE);
    assign nn_clear        = (state == S_CLEAR);
    assign done            = (state == S_DONE);
    assign stall           = (state == S_FETCH) && fifo_empty;
    assign nn_input_spikes = (state == S_APPLY) ? hold : '0;

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_count_out
        assign spike_count[g*COUNT_WIDTH +: COUNT_WIDTH] = cnt[g];
    end

    // Next-state decode; abort overrides everything and drops straight to
    // idle, which also makes abort win over a simultaneous start.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_next = S_CLEAR;
                S_CLEAR: state_next = (num_steps_lat == '0) ? S_DONE : S_FETCH;
                S_FETCH: if (!fifo_empty) state_next = S_APPLY;
                S_APPLY: begin
                    if (last_phase) begin
                        state_next = (step_next == num_steps_lat) ? S_DONE : S_FETCH;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FIFO storage needs no reset: emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_spikes;
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Run datapath: latch the step count, clear results at run start, load a
    // vector per timestep, accumulate output spikes and bump the counters.
    // On abort the popped vector is dropped but counts and step_idx remain
    // so the host can read the partial run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_steps_lat <= '0;
            hold          <= '0;
            accum         <= '0;
            phase         <= '0;
            step_idx      <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cnt[i] <= '0;
            end
        end else if (abort) begin
            hold <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_steps_lat <= num_steps;
                    end
                end
                S_CLEAR: begin
                    step_idx <= '0;
                    accum    <= '0;
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        cnt[i] <= '0;
                    end
                end
                S_FETCH: begin
                    if (!fifo_empty) begin
                        hold  <= fifo_mem[rd_ptr];
                        phase <= '0;
                        accum <= '0;
                    end
                end
                S_APPLY: begin
                    accum <= step_sample;
                    phase <= phase + PHASE_W'(1);
                    if (last_phase) begin
                        step_idx <= step_next;
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            if (step_sample[i] && (cnt[i] != COUNT_MAX)) begin
                                cnt[i] <= cnt[i] + COUNT_WIDTH'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_timestep_scheduler.sv
// ---------------------------------------------------------------------------
// tb_nn_timestep_scheduler
//
// Self-checking bench for nn_timestep_scheduler. A reference model kept as a
// queue of pushed vectors plus a per-run timeline (clear, fetch/stall, apply
// windows, done) predicts every control output each cycle, and integer
// arithmetic predicts the saturating per-neuron counts and step index.
// Stimulus (vectors, core output spikes, stray start pulses) is randomized.
// ---------------------------------------------------------------------------
module tb_nn_timestep_scheduler;

    localparam int NN    = 4;
    localparam int DEPTH = 8;
    localparam int SC    = 4;
    localparam int CW    = 8;
    localparam int SW    = 16;
    localparam int CMAX  = (1 << CW) - 1;

    localparam int M_CLEAR = 0;
    localparam int M_FETCH = 1;
    localparam int M_APPLY = 2;
    localparam int M_DONE  = 3;
    localparam int M_IDLE  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [SW-1:0]     num_steps;
    logic              in_valid;
    logic [NN-1:0]     in_spikes;
    logic              in_ready;
    logic              nn_clear;
    logic [NN-1:0]     nn_input_spikes;
    logic [NN-1:0]     nn_output_spikes;
    logic [NN*CW-1:0]  spike_count;
    logic [SW-1:0]     step_idx;
    logic              busy;
    logic              stall;
    logic              done;

    int                numChecks = 0;
    int                numFails  = 0;
    logic [NN-1:0]     modelQ[$];
    int                expCnt[NN];
    int                expStep;

    always #5 clk = ~clk;

    nn_timestep_scheduler #(
        .NUM_NEURONS(NN),
        .FIFO_DEPTH (DEPTH),
        .STEP_CYCLES(SC),
        .COUNT_WIDTH(CW),
        .STEPS_WIDTH(SW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .num_steps       (num_steps),
        .in_valid        (in_valid),
        .in_spikes       (in_spikes),
        .in_ready        (in_ready),
        .nn_clear        (nn_clear),
        .nn_input_spikes (nn_input_spikes),
        .nn_output_spikes(nn_output_spikes),
        .spike_count     (spike_count),
        .step_idx        (step_idx),
        .busy            (busy),
        .stall           (stall),
        .done            (done)
    );

    // Single comparison point: counts every check, reports each mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven
    // and registered outputs are stable.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n            = 1'b0;
        start            = 1'b0;
        abort            = 1'b0;
        num_steps        = '0;
        in_valid         = 1'b0;
        in_spikes        = '0;
        nn_output_spikes = '0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        modelQ.delete();
        for (int i = 0; i < NN; i++) expCnt[i] = 0;
        expStep = 0;
    endtask

    task automatic checkCounts(input string tag);
        for (int i = 0; i < NN; i++) begin
            checkOutput($sformatf("%s cnt%0d", tag, i), 64'(spike_count[i*CW +: CW]), 64'(expCnt[i]));
        end
        checkOutput($sformatf("%s step_idx", tag), 64'(step_idx), 64'(expStep));
    endtask

    // Push one vector while idle; the model accepts it only if not full.
    task automatic pushOne(input logic [NN-1:0] vec);
        in_valid  = 1'b1;
        in_spikes = vec;
        @(negedge clk);
        checkOutput("in_ready", 64'(in_ready), 64'(modelQ.size() < DEPTH));
        if (modelQ.size() < DEPTH) modelQ.push_back(vec);
        nextCycle();
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int count);
        for (int k = 0; k < count; k++) begin
            pushOne(NN'($urandom));
        end
    endtask

    // Start a run of n steps and follow it cycle by cycle until idle.
    // outMode: 0 random core spikes, 1 core echoes last cycle's input,
    // 2 random with neuron 0 always firing. abortAt / feedAt are cycle
    // numbers (cycle 1 = first cycle after start), 0 = never.
    task automatic runSequence(input int n, input int abortAt, input int outMode,
                               input bit autoFeed, input int feedAt);
        logic [NN-1:0] cur, acc, outv, prevIn, vec, expIn;
        logic [8:0]    expCtl;
        int            mode, ph, c;
        bit            ab, vld, pushOk, idleNow;
        start            = 1'b1;
        num_steps        = SW'(n);
        abort            = 1'b0;
        in_valid         = 1'b0;
        nn_output_spikes = '0;
        nextCycle();
        mode   = M_CLEAR;
        c      = 1;
        ph     = 0;
        cur    = '0;
        acc    = '0;
        prevIn = '0;
        while (1) begin
            idleNow = (mode == M_IDLE);
            case (outMode)
                0:       outv = NN'($urandom);
                1:       outv = prevIn;
                default: outv = NN'($urandom) | NN'(1);
            endcase
            nn_output_spikes = outv;
            start     = idleNow ? 1'b0 : 1'($urandom_range(0, 1));
            num_steps = SW'($urandom);
            ab        = (c == abortAt);
            abort     = ab;
            vld       = autoFeed || (c == feedAt);
            vec       = NN'($urandom);
            in_valid  = vld;
            in_spikes = vec;
            @(negedge clk);
            expIn  = (mode == M_APPLY) ? cur : '0;
            expCtl = {mode != M_IDLE, mode == M_CLEAR, mode == M_DONE,
                      (mode == M_FETCH) && (modelQ.size() == 0),
                      modelQ.size() < DEPTH, expIn};
            checkOutput($sformatf("ctl n=%0d cyc%0d", n, c),
                        64'({busy, nn_clear, done, stall, in_ready, nn_input_spikes}),
                        64'(expCtl));
            prevIn = expIn;
            pushOk = vld && (modelQ.size() < DEPTH);
            if (ab) begin
                mode = M_IDLE;
            end else begin
                case (mode)
                    M_CLEAR: begin
                        for (int i = 0; i < NN; i++) expCnt[i] = 0;
                        expStep = 0;
                        mode = (n == 0) ? M_DONE : M_FETCH;
                    end
                    M_FETCH: begin
                        if (modelQ.size() > 0) begin
                            cur  = modelQ.pop_front();
                            acc  = '0;
                            ph   = 0;
                            mode = M_APPLY;
                        end
                    end
                    M_APPLY: begin
                        acc = acc | outv;
                        if (ph == SC - 1) begin
                            for (int i = 0; i < NN; i++) begin
                                if (acc[i] && expCnt[i] < CMAX) expCnt[i]++;
                            end
                            expStep++;
                            mode = (expStep == n) ? M_DONE : M_FETCH;
                        end else begin
                            ph++;
                        end
                    end
                    M_DONE:  mode = M_IDLE;
                    default: mode = M_IDLE;
                endcase
            end
            if (pushOk) modelQ.push_back(vec);
            nextCycle();
            c++;
            if (idleNow) break;
            if (c > 6000) begin
                checkOutput("run timeout", 64'd1, 64'd0);
                break;
            end
        end
        start            = 1'b0;
        abort            = 1'b0;
        in_valid         = 1'b0;
        nn_output_spikes = '0;
        checkCounts($sformatf("run n=%0d", n));
    endtask

    initial begin
        int k;
        doReset();
        checkOutput("reset ctl", 64'({busy, nn_clear, done, stall, in_ready, nn_input_spikes}),
                    64'(9'b0_0001_0000));
        checkCounts("reset");

        // Three one-hot vectors with an echoing core stub.
        pushOne(4'b0001);
        pushOne(4'b0010);
        pushOne(4'b0100);
        runSequence(3, 0, 1, 1'b0, 0);
        checkOutput("echo counts", 64'(spike_count), 64'(32'h0001_0101));
        checkOutput("echo step_idx", 64'(step_idx), 64'd3);

        // Starvation: second step stalls until a vector arrives 5 cycles later.
        pushOne(NN'($urandom));
        runSequence(2, 0, 0, 1'b0, 11);
        checkOutput("stall step_idx", 64'(step_idx), 64'd2);

        // Abort in the second apply cycle of step 2; unpopped vectors remain.
        applyStimulus(4);
        runSequence(4, 9, 0, 1'b0, 0);
        checkOutput("abort step_idx", 64'(step_idx), 64'd1);
        checkOutput("abort leftover", 64'(modelQ.size()), 64'd2);
        runSequence(2, 0, 0, 1'b0, 0);

        // Fill past capacity, then drain all eight in order.
        applyStimulus(10);
        runSequence(8, 0, 0, 1'b0, 0);

        // Zero-length run.
        runSequence(0, 0, 0, 1'b0, 0);

        // start and abort together while idle: abort wins.
        start     = 1'b1;
        abort     = 1'b1;
        num_steps = SW'(5);
        nextCycle();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start+abort busy", 64'(busy), 64'd0);
        nextCycle();
        checkOutput("start+abort busy2", 64'(busy), 64'd0);

        // Randomized runs.
        for (int r = 0; r < 4; r++) begin
            applyStimulus($urandom_range(1, DEPTH));
            k = $urandom_range(1, modelQ.size());
            runSequence(k, 0, 0, 1'b0, 0);
        end

        // Saturation: neuron 0 fires every step for more steps than fit.
        runSequence(260, 0, 2, 1'b1, 0);
        checkOutput("sat cnt0", 64'(spike_count[CW-1:0]), 64'(CMAX));
        checkOutput("sat step_idx", 64'(step_idx), 64'd260);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
